// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: MSB-first serializer of a 1..8 bit frame with Busy/Done handshake.
// Optional even-parity trailer bit when TX_PARITY_EN is defined.
module serial_pattern_tx (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Start,
  input  logic [7:0] Data,
  input  logic [2:0] Len,
  output logic       Out1,
  output logic       Busy,
  output logic       Done
);
  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
  state_t     r_state, w_state;
  logic [7:0] r_data, w_data;
  logic [2:0] r_cnt, w_cnt, w_cnt_dec;
  logic       r_out, w_out, r_busy, w_busy, r_done, w_done;
`ifdef TX_PARITY_EN
  logic       r_par, w_par, r_pbit, w_pbit;
`endif
  assign Out1 = r_out;
  assign Busy = r_busy;
  assign Done = r_done;
  assign w_cnt_dec = r_cnt - 3'd1;
  always_comb begin
    w_state = r_state;
    w_data  = r_data;
    w_cnt   = r_cnt;
    w_out   = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
`ifdef TX_PARITY_EN
    w_par   = r_par;
    w_pbit  = r_pbit;
`endif
    case (r_state)
      IDLE, FIN: begin
        w_state = Start ? SHIFT : IDLE;
        if (Start) begin
          w_data = Data;
          w_cnt  = Len;
          w_out  = Data[Len];
          w_busy = 1'b1;
`ifdef TX_PARITY_EN
          w_par  = Data[Len];
          w_pbit = 1'b0;
`endif
        end
      end
      SHIFT: begin
        if (r_cnt != 3'd0) begin
          w_cnt  = w_cnt_dec;
          w_out  = r_data[w_cnt_dec];
          w_busy = 1'b1;
`ifdef TX_PARITY_EN
          w_par  = r_par ^ r_data[w_cnt_dec];
`endif
        end else begin
`ifdef TX_PARITY_EN
          // r_par already holds the XOR of every transmitted bit
          if (!r_pbit) begin
            w_pbit = 1'b1;
            w_out  = r_par;
            w_busy = 1'b1;
          end else begin
            w_state = FIN;
            w_done  = 1'b1;
          end
`else
          w_state = FIN;
          w_done  = 1'b1;
`endif
        end
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_data  <= 8'd0;
      r_cnt   <= 3'd0;
      r_out   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_data  <= w_data;
      r_cnt   <= w_cnt;
      r_out   <= w_out;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end
`ifdef TX_PARITY_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_par  <= 1'b0;
      r_pbit <= 1'b0;
    end else begin
      r_par  <= w_par;
      r_pbit <= w_pbit;
    end
  end
`endif
endmodule

// File: doc/serial_pattern_tx.md
SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

Interface
REQ-001 The block SHALL have port CLK, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have port Start, input, 1 bit: request to transmit one frame; sampled only while Busy=0.
REQ-004 The block SHALL have port Data, input, 8 bits: frame payload; captured on the accepting edge.
REQ-005 The block SHALL have port Len, input, 3 bits: frame length minus one (N = Len+1, range 1..8); captured with Data.
REQ-006 The block SHALL have port Out1, output, 1 bit: registered serial bit stream; idle level 0.
REQ-007 The block SHALL have port Busy, output, 1 bit: registered; high while a frame is being shifted out.
REQ-008 The block SHALL have port Done, output, 1 bit: registered; one-cycle pulse after the last bit of a frame.

Function
REQ-009 The block SHALL implement a state machine with three states: IDLE, SHIFT and FIN.
REQ-010 In IDLE with Start=1 at edge k, the block SHALL capture Data and Len into internal registers, load a bit counter with Len, and enter SHIFT.
REQ-011 After edge k, Out1 SHALL equal Data[Len], and Busy SHALL be 1.
REQ-012 Each subsequent edge in SHIFT SHALL present the next lower bit (MSB-first), each bit held for exactly one cycle; Out1=Data[0] SHALL hold after edge k+N-1.
REQ-013 When the last bit has been presented, the next edge SHALL enter FIN with Out1=0, Busy=0 and Done=1.
REQ-014 FIN SHALL last exactly one cycle and then enter IDLE with Done=0.
REQ-015 A Start asserted during FIN SHALL be accepted as in IDLE, giving a minimum one-cycle gap (Out1=0) between frames.
REQ-016 Start, Data and Len SHALL be ignored while Busy=1; changes to Data or Len mid-frame SHALL NOT affect the frame in flight.
REQ-017 In IDLE with Start=0, the outputs SHALL hold Out1=0, Busy=0 and Done=0.
REQ-018 Len=0 SHALL produce a one-bit frame (Data[0] only); bits above Data[Len] SHALL never be transmitted.
REQ-019 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Reset
REQ-020 When RST=1 at a rising edge, the block SHALL set the state to IDLE and set Out1=0, Busy=0, Done=0 and the bit counter to 0, taking priority over Start.
REQ-021 A reset during SHIFT or FIN SHALL abort the frame, and no Done pulse SHALL follow.
REQ-022 A Start asserted on the same edge as RST SHALL be discarded.

Configuration
REQ-023 The feature SHALL be controlled by macro TX_PARITY_EN.
REQ-024 With TX_PARITY_EN defined, the block SHALL present one extra bit after Data[0] for one cycle: the even-parity bit, equal to the XOR of the N transmitted bits.
REQ-025 With TX_PARITY_EN defined, Busy SHALL remain 1 through the parity cycle, and Done SHALL follow it, so each frame occupies N+1 Busy cycles.
REQ-026 With TX_PARITY_EN undefined, the block SHALL add no parity cycle and no parity logic, and frames SHALL occupy N Busy cycles.

Verification
REQ-027 The bench SHALL cover: Reset, then Data=8'hB2, Len=7, one Start pulse -> Out1 = 1,0,1,1,0,0,1,0 on consecutive cycles, Busy high for 8 cycles, then Done=1 for exactly 1 cycle.
REQ-028 The bench SHALL cover: Data=8'h05, Len=2 -> Out1 = 1,0,1, Busy high for 3 cycles; Data[7:3] never appear on Out1.
REQ-029 The bench SHALL cover: Start held high continuously with Data=8'h81, Len=7 -> frames repeat with exactly one Out1=0 gap cycle (the FIN cycle); Start during Busy is ignored.
REQ-030 The bench SHALL cover: RST=1 asserted on the 4th bit of a Len=7 frame -> the next cycle shows Out1=0, Busy=0, Done=0, no later Done pulse, and IDLE is held until a new Start.
REQ-031 The bench SHALL cover: with TX_PARITY_EN defined, Data=8'h07, Len=3 -> Out1 = 0,1,1,1 then parity bit 1, Busy high for 5 cycles, then Done.
REQ-032 The bench SHALL cover: Data changed to 8'hFF mid-frame after Data=8'h00, Len=7 was accepted -> Out1 stays 0 for all 8 bits.
